// File: rtl/ring_hs_ctrl_pkg.sv
// ring_ctrl_pkg: state encoding and default parameters for the ring handshake controller
package ring_ctrl_pkg;
    localparam int SYNC_STAGES_DEF  = 2;
    localparam int CNT_W_DEF        = 16;
    localparam int RST_CYCLES_DEF   = 4;
    localparam int TIMEOUT_CLKS_DEF = 1023;
    typedef logic [2:0] state_t;
    localparam state_t IDLE     = 3'd0;
    localparam state_t RING_RST = 3'd1;
    localparam state_t REQ_UP   = 3'd2;
    localparam state_t REQ_DN   = 3'd3;
    localparam state_t DRAIN    = 3'd4;
    localparam state_t ABORT    = 3'd5;
endpackage

// File: rtl/ring_hs_ctrl_sync.sv
// ring_sync: multi-flop synchronizer for an asynchronous ring handshake wire
module ring_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr;
    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else sr <= {sr[STAGES-2:0], d};
    end
    assign q = sr[STAGES-1];
endmodule

// File: rtl/ring_hs_ctrl.sv
// ring_hs_ctrl: sequences token injection into and consumption from a self-timed handshake ring
module ring_hs_ctrl
    import ring_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int RST_CYCLES   = RST_CYCLES_DEF,
    parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_tokens,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] tok_in_cnt,
    output logic [CNT_W-1:0] tok_out_cnt,
    output logic [CNT_W-1:0] cycle_clks,
    output logic             cycle_valid,
    output logic             ring_rst,
    output logic             lr,
    input  logic             la,
    input  logic             rr,
    output logic             ra
);
    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int WD_W = $clog2(TIMEOUT_CLKS + 1);

    state_t           state, state_n;
    logic             la_s, rr_s, la_q, rr_q, cyc_run;
    logic             la_rise, la_fall, rr_rise, rr_fall, any_edge;
    logic             active, wd_exp, rr_act, drain_ok, start_ok, acc;
    logic [CNT_W-1:0] n_tok, cyc_cnt;
    logic [RC_W-1:0]  rst_cnt;
    logic [WD_W-1:0]  wd;

    ring_sync #(.STAGES(SYNC_STAGES)) u_la_sync (.clk(clk), .rst_n(rst_n), .d(la), .q(la_s));
    ring_sync #(.STAGES(SYNC_STAGES)) u_rr_sync (.clk(clk), .rst_n(rst_n), .d(rr), .q(rr_s));

    assign la_rise  = la_s & ~la_q;
    assign la_fall  = ~la_s & la_q;
    assign rr_rise  = rr_s & ~rr_q;
    assign rr_fall  = ~rr_s & rr_q;
    assign any_edge = la_rise | la_fall | rr_rise | rr_fall;
    assign active   = state == REQ_UP || state == REQ_DN || state == DRAIN;
    assign wd_exp   = active && !any_edge && wd == WD_W'(TIMEOUT_CLKS - 1);
    assign rr_act   = !ring_rst && active && !wd_exp;
    assign drain_ok = tok_out_cnt == n_tok && !lr && !la_s && !rr_s && !ra;
    assign start_ok = start && state == IDLE;
    assign acc      = la_rise && state == REQ_UP;

    // Next state; wd_exp excludes edge cycles so a completing edge always beats the watchdog
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = start ? RING_RST : IDLE;
            RING_RST: if (rst_cnt == RC_W'(RST_CYCLES - 1)) state_n = n_tok == '0 ? DRAIN : REQ_UP;
            REQ_UP:   state_n = wd_exp ? ABORT : la_rise ? REQ_DN : REQ_UP;
            REQ_DN:   state_n = wd_exp ? ABORT : !la_fall ? REQ_DN : tok_in_cnt < n_tok ? REQ_UP : DRAIN;
            DRAIN:    state_n = drain_ok ? IDLE : wd_exp ? ABORT : DRAIN;
            default:  state_n = IDLE;
        endcase
    end

    // Previous synchronized levels for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {la_q, rr_q} <= '0;
        else {la_q, rr_q} <= {la_s, rr_s};
    end

    // FSM state, registered ring-facing handshake wires, run status and watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ring_rst <= 1'b1;
            lr       <= 1'b0;
            ra       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            n_tok    <= '0;
            rst_cnt  <= '0;
            wd       <= '0;
        end else begin
            state    <= state_n;
            ring_rst <= state_n == IDLE || state_n == RING_RST;
            lr       <= state == REQ_UP && state_n == REQ_UP;
            ra       <= rr_act && rr_s;
            busy     <= state_n != IDLE;
            done     <= state != IDLE && state_n == IDLE;
            timeout  <= !start_ok && (timeout || state == ABORT);
            n_tok    <= start_ok ? n_tokens : n_tok;
            rst_cnt  <= state == RING_RST ? rst_cnt + 1'b1 : '0;
            wd       <= (!active || any_edge || (state_n == REQ_UP && state != REQ_UP)) ? '0 : wd + 1'b1;
        end
    end

    // Token counts and saturating la-to-la period, all cleared by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_in_cnt  <= '0;
            tok_out_cnt <= '0;
            cyc_cnt     <= '0;
            cyc_run     <= 1'b0;
            cycle_clks  <= '0;
            cycle_valid <= 1'b0;
        end else if (start_ok) begin
            tok_in_cnt  <= '0;
            tok_out_cnt <= '0;
            cyc_cnt     <= '0;
            cyc_run     <= 1'b0;
            cycle_clks  <= '0;
            cycle_valid <= 1'b0;
        end else begin
            if (acc) tok_in_cnt <= tok_in_cnt + 1'b1;
            if (rr_act && rr_rise && tok_out_cnt < n_tok) tok_out_cnt <= tok_out_cnt + 1'b1;
            cyc_cnt <= acc ? CNT_W'(1) : (cyc_run && cyc_cnt != '1) ? cyc_cnt + 1'b1 : cyc_cnt;
            cyc_run <= cyc_run || acc;
            if (acc && cyc_run) begin
                cycle_clks  <= cyc_cnt;
                cycle_valid <= 1'b1;
            end
        end
    end
endmodule

// File: doc/ring_hs_ctrl.md
# ring_hs_ctrl

Clocked controller that sequences the self-timed handshake ring from a synchronous test harness. It holds the ring in reset and injects a programmed number of tokens through four-phase handshakes on the left channel (lr/la). It consumes tokens on the right channel (rr/ra) and reports token counts, the la-to-la cycle time in clock periods, and a stall watchdog. It sits between the on-chip test/config logic and the ring's asynchronous ports.

## Interface
- SYNC_STAGES, 2: flops per synchronizer on la and rr (≥2)
- CNT_W, 16: width of token counters and cycle counter
- RST_CYCLES, 4: clocks ring_rst is held after start (≥1)
- TIMEOUT_CLKS, 1023: clocks without a synchronized la/rr edge before abort

- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run when idle
- n_tokens  in  CNT_W  tokens to inject; sampled on accepted start
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run (normal or abort)
- timeout  out  1  sticky abort flag; cleared by next accepted start
- tok_in_cnt  out  CNT_W  tokens accepted by ring (la rises)
- tok_out_cnt  out  CNT_W  tokens consumed (rr rises)
- cycle_clks  out  CNT_W  clocks between last two la rises, saturating
- cycle_valid  out  1  cycle_clks holds a measurement from this run
- ring_rst  out  1  active-high reset to ring
- lr  out  1  left request to ring
- la  in  1  left ack from ring, asynchronous
- rr  in  1  right request from ring, asynchronous
- ra  out  1  right ack to ring

## Operation
- Reset values: ring_rst=1, lr=0, ra=0, busy=0, done=0, timeout=0, all counters 0, cycle_valid=0; FSM=IDLE.
- la_s, rr_s: SYNC_STAGES-flop synchronized copies; edge detect on registered previous value.
- Left FSM:
  - IDLE: ring_rst=1. start accepted → latch n_tokens, clear counters/timeout/cycle_valid, busy=1 → RING_RST.
  - RING_RST: hold ring_rst=1 for RST_CYCLES clocks, then ring_rst=0. If n_tokens=0 → DRAIN, else → REQ_UP.
  - REQ_UP: lr=1. On la_s rise → tok_in_cnt++ → REQ_DN.
  - REQ_DN: lr=0. On la_s fall → REQ_UP if tok_in_cnt<n_tokens, else DRAIN.
  - DRAIN: wait until tok_out_cnt==n_tokens and lr=la_s=rr_s=ra=0 → pulse done, busy=0 → IDLE.
  - ABORT, from any busy state on watchdog expiry: lr=0, ra=0, timeout=1, pulse done → IDLE.
- Right side, active while ring_rst=0 and not aborted:
  - ra registered copy of rr_s.
  - tok_out_cnt++ on rr_s rise.
- Cycle counter: runs from the first la_s rise; on each later la_s rise, load cycle_clks and set cycle_valid; saturate at 2^CNT_W−1.
- Watchdog: clears on any la_s/rr_s edge and on entering REQ_UP. Counts in RING_RST-exit states (REQ_UP, REQ_DN, DRAIN) only. Expiry at TIMEOUT_CLKS.
- start while busy is ignored. rst_n assertion mid-run forces reset values immediately, with no done pulse.
- Counters do not wrap: n_tokens bounds both counts.

## Timing
- Accepted start → ring_rst falls after RST_CYCLES+1 clocks. lr rises the cycle after ring_rst falls.
- la edge → FSM reaction after SYNC_STAGES+1 clocks; rr edge → ra change after SYNC_STAGES+1 clocks.
- done: exactly one cycle, the cycle busy falls.
- Simultaneous la_s and rr_s edges are both processed in the same cycle.
- Watchdog expiry in the same cycle as a completing edge: edge wins, no abort.

## Structure
- Package ring_ctrl_pkg holds the FSM state enum (IDLE, RING_RST, REQ_UP, REQ_DN, DRAIN, ABORT) and the default parameter constants.
- Sub-module ring_sync: SYNC_STAGES-deep synchronizer with async active-low reset to 0, instantiated for la and rr.

## Test plan
- Behavioural ring model (3-clock stage delay, ring of 2), n_tokens=5, start → tok_in_cnt=5, tok_out_cnt=5, single done, timeout=0, cycle_valid=1, cycle_clks equal to the model period.
- n_tokens=0, start → done 1 cycle after ring_rst falls, counts 0, lr never rises.
- Model stops acking la after 2 tokens, TIMEOUT_CLKS=63 → timeout=1, done pulse, lr=0, tok_in_cnt=2.
- start pulsed again while busy → ignored; run completes with the original n_tokens.
- rst_n pulled low mid-REQ_DN → immediate reset values, ring_rst=1, no done pulse; next start completes normally.
- Model period > 2^CNT_W with CNT_W=4 → cycle_clks=15 (saturated).
